// File: rtl/note_lane_engine.sv
// Multi-lane falling-note engine: spawns notes per lane, moves them on a divided
// tick, resolves presses against a strike window and answers pixel queries.
module note_lane_engine #(
  parameter int NUM_LANES  = 4,
  parameter int SLOTS      = 4,
  parameter int TICK_DIV   = 833333,
  parameter int SPEED      = 2,
  parameter int NOTE_W     = 100,
  parameter int NOTE_H     = 20,
  parameter int LANE_X0    = 120,
  parameter int LANE_PITCH = 100,
  parameter int SCREEN_H   = 480,
  parameter int STRIKE_Y   = 440,
  parameter int HIT_WIN    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 spawn_valid,
  input  logic [2:0]           spawn_lane,
  output logic                 spawn_ready,
  input  logic [NUM_LANES-1:0] hit_req,
  output logic [NUM_LANES-1:0] hit_pulse,
  output logic [NUM_LANES-1:0] bad_press,
  output logic [NUM_LANES-1:0] miss_pulse,
  input  logic [9:0]           h_count,
  input  logic [9:0]           v_count,
  output logic                 note_visible,
  output logic [2:0]           note_lane
);

  localparam int              CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [10:0]     WIN_LO   = 11'(STRIKE_Y - HIT_WIN);
  localparam logic [10:0]     WIN_HI   = 11'(STRIKE_Y + HIT_WIN);
  localparam logic [10:0]     MOVE_LIM = 11'(SCREEN_H + NOTE_H - 1);
  localparam logic [10:0]     SPD_W    = 11'(SPEED);
  localparam logic [10:0]     NH_W     = 11'(NOTE_H);

  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic                                   tick;
  logic [NUM_LANES-1:0][SLOTS-1:0]        act_q, act_d;
  logic [NUM_LANES-1:0][SLOTS-1:0][9:0]   y_q, y_d;
  logic [NUM_LANES-1:0]                   hit_q, hit_d;
  logic [NUM_LANES-1:0]                   bad_q, bad_d;
  logic [NUM_LANES-1:0]                   miss_q, miss_d;
  logic                                   spawn_fire;
  logic [SLOTS-1:0]                       hit_sel;
  logic                                   hit_found;
  logic                                   spawn_done;
  logic [10:0]                            bot;

  logic [11:0]                            px, x_lo;
  logic [10:0]                            py, top;

  assign tick = start && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  // Readiness looks only at pre-edge occupancy, so a slot freed this cycle waits a cycle.
  always_comb begin
    spawn_ready = 1'b0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (3'(l) == spawn_lane) begin
        for (int unsigned s = 0; s < SLOTS; s++) begin
          if (!act_q[l][s]) spawn_ready = start;
        end
      end
    end
  end

  assign spawn_fire = spawn_valid && spawn_ready;

  always_comb begin
    act_d      = act_q;
    y_d        = y_q;
    hit_d      = '0;
    bad_d      = '0;
    miss_d     = '0;
    hit_sel    = '0;
    hit_found  = 1'b0;
    spawn_done = 1'b0;
    bot        = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      hit_sel   = '0;
      hit_found = 1'b0;
      if (start && hit_req[l]) begin
        for (int unsigned s = 0; s < SLOTS; s++) begin
          bot = {1'b0, y_q[l][s]} + NH_W;
          if (!hit_found && act_q[l][s] && bot >= WIN_LO && bot <= WIN_HI) begin
            hit_found     = 1'b1;
            hit_sel[s]    = 1'b1;
            act_d[l][s]   = 1'b0;
          end
        end
        hit_d[l] = hit_found;
        bad_d[l] = !hit_found;
      end
      // A slot removed by a hit is excluded from motion, so it can never also miss.
      if (tick) begin
        for (int unsigned s = 0; s < SLOTS; s++) begin
          if (act_q[l][s] && !hit_sel[s]) begin
            if ({1'b0, y_q[l][s]} + SPD_W + NH_W <= MOVE_LIM) begin
              y_d[l][s] = y_q[l][s] + 10'(SPEED);
            end else begin
              act_d[l][s] = 1'b0;
              miss_d[l]   = 1'b1;
            end
          end
        end
      end
      if (spawn_fire && 3'(l) == spawn_lane) begin
        spawn_done = 1'b0;
        for (int unsigned s = 0; s < SLOTS; s++) begin
          if (!spawn_done && !act_q[l][s]) begin
            act_d[l][s] = 1'b1;
            y_d[l][s]   = '0;
            spawn_done  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      act_q  <= '0;
      y_q    <= '0;
      hit_q  <= '0;
      bad_q  <= '0;
      miss_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      y_q    <= y_d;
      hit_q  <= hit_d;
      bad_q  <= bad_d;
      miss_q <= miss_d;
    end
  end

  assign hit_pulse  = hit_q;
  assign bad_press  = bad_q;
  assign miss_pulse = miss_q;

  assign px = {2'b00, h_count};
  assign py = {1'b0, v_count};

  always_comb begin
    note_visible = 1'b0;
    note_lane    = '0;
    x_lo         = '0;
    top          = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      x_lo = 12'(LANE_X0 + l * LANE_PITCH);
      for (int unsigned s = 0; s < SLOTS; s++) begin
        top = {1'b0, y_q[l][s]};
        if (!note_visible && act_q[l][s] &&
            px >= x_lo && px < x_lo + 12'(NOTE_W) &&
            py >= top && py < top + NH_W) begin
          note_visible = 1'b1;
          note_lane    = 3'(l);
        end
      end
    end
  end

endmodule

// File: tb/tb_note_lane_engine.sv
// Self-checking bench for note_lane_engine: directed scenarios plus randomized
// traffic, all checked against a behavioural lane/slot model.
module tb_note_lane_engine;

  localparam int NL = 4, NS = 4, TD = 4, SP = 2, NW = 100, NH = 20;
  localparam int X0 = 120, PITCH = 100, SH = 480, SY = 440, HW = 16;

  logic          clk, rst_n, start, spawn_valid, spawn_ready;
  logic [2:0]    spawn_lane, note_lane;
  logic [NL-1:0] hit_req, hit_pulse, bad_press, miss_pulse;
  logic [9:0]    h_count, v_count;
  logic          note_visible;

  note_lane_engine #(
    .NUM_LANES(NL), .SLOTS(NS), .TICK_DIV(TD), .SPEED(SP), .NOTE_W(NW),
    .NOTE_H(NH), .LANE_X0(X0), .LANE_PITCH(PITCH), .SCREEN_H(SH),
    .STRIKE_Y(SY), .HIT_WIN(HW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .spawn_valid(spawn_valid),
    .spawn_lane(spawn_lane), .spawn_ready(spawn_ready), .hit_req(hit_req),
    .hit_pulse(hit_pulse), .bad_press(bad_press), .miss_pulse(miss_pulse),
    .h_count(h_count), .v_count(v_count), .note_visible(note_visible),
    .note_lane(note_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: per-lane note table with plain integer positions.
  int m_act[NL][NS];
  int m_y[NL][NS];
  int m_cnt;
  int m_hit[NL], m_bad[NL], m_miss[NL];

  task automatic m_reset();
    for (int l = 0; l < NL; l++) begin
      for (int s = 0; s < NS; s++) begin
        m_act[l][s] = 0;
        m_y[l][s]   = 0;
      end
      m_hit[l] = 0; m_bad[l] = 0; m_miss[l] = 0;
    end
    m_cnt = 0;
  endtask

  function automatic int m_ready(int lane);
    if (!start || lane >= NL) return 0;
    for (int s = 0; s < NS; s++) if (m_act[lane][s] == 0) return 1;
    return 0;
  endfunction

  function automatic int m_vis(int h, int v);
    for (int l = 0; l < NL; l++) begin
      if (h >= X0 + l * PITCH && h < X0 + l * PITCH + NW) begin
        for (int s = 0; s < NS; s++)
          if (m_act[l][s] != 0 && v >= m_y[l][s] && v < m_y[l][s] + NH) return l;
      end
    end
    return -1;
  endfunction

  task automatic m_edge();
    int na[NL][NS];
    int ny[NL][NS];
    int fire, tk, hs, b, placed;
    na   = m_act;
    ny   = m_y;
    tk   = (start && m_cnt == TD - 1) ? 1 : 0;
    fire = (spawn_valid && m_ready(int'(spawn_lane)) != 0) ? 1 : 0;
    for (int l = 0; l < NL; l++) begin
      m_hit[l] = 0; m_bad[l] = 0; m_miss[l] = 0;
      hs = -1;
      if (start && hit_req[l]) begin
        for (int s = 0; s < NS; s++) begin
          b = m_y[l][s] + NH;
          if (hs < 0 && m_act[l][s] != 0 && b >= SY - HW && b <= SY + HW) hs = s;
        end
        if (hs >= 0) begin na[l][hs] = 0; m_hit[l] = 1; end
        else m_bad[l] = 1;
      end
      if (tk != 0) begin
        for (int s = 0; s < NS; s++) begin
          if (m_act[l][s] != 0 && s != hs) begin
            if (m_y[l][s] + SP <= SH - 1) ny[l][s] = m_y[l][s] + SP;
            else begin na[l][s] = 0; m_miss[l] = 1; end
          end
        end
      end
      if (fire != 0 && int'(spawn_lane) == l) begin
        placed = 0;
        for (int s = 0; s < NS; s++) begin
          if (placed == 0 && m_act[l][s] == 0) begin
            na[l][s] = 1; ny[l][s] = 0; placed = 1;
          end
        end
      end
    end
    m_act = na;
    m_y   = ny;
    if (start) m_cnt = (m_cnt + 1) % TD;
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic cycle();
    int ml;
    logic [NL-1:0] eh, eb, em;
    @(negedge clk);
    check_eq("spawn_ready", 32'(spawn_ready), m_ready(int'(spawn_lane)));
    ml = m_vis(int'(h_count), int'(v_count));
    check_eq("note_visible", 32'(note_visible), (ml >= 0) ? 1 : 0);
    check_eq("note_lane", 32'(note_lane), (ml >= 0) ? ml : 0);
    for (int l = 0; l < NL; l++) begin
      eh[l] = (m_hit[l] != 0);
      eb[l] = (m_bad[l] != 0);
      em[l] = (m_miss[l] != 0);
    end
    check_eq("hit_pulse", 32'(hit_pulse), 32'(eh));
    check_eq("bad_press", 32'(bad_press), 32'(eb));
    check_eq("miss_pulse", 32'(miss_pulse), 32'(em));
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    int l, s, hh, vv;
    start       = ($urandom_range(0, 15) != 0);
    spawn_valid = ($urandom_range(0, 39) == 0);
    spawn_lane  = 3'($urandom_range(0, 5));
    for (int k = 0; k < NL; k++) hit_req[k] = ($urandom_range(0, 19) == 0);
    l = int'($urandom_range(0, NL - 1));
    s = int'($urandom_range(0, NS - 1));
    if ($urandom_range(0, 1) == 1 && m_act[l][s] != 0) begin
      vv = m_y[l][s] + int'($urandom_range(0, NH + 3)) - 2;
      hh = X0 + l * PITCH + int'($urandom_range(0, NW + 3)) - 2;
      if (vv < 0) vv = 0;
      if (vv > 1023) vv = 1023;
    end else begin
      hh = int'($urandom_range(0, 639));
      vv = int'($urandom_range(0, 479));
    end
    h_count = 10'(hh);
    v_count = 10'(vv);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; spawn_valid = 1'b0; spawn_lane = '0;
    hit_req = '0; h_count = '0; v_count = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hit", 32'(hit_pulse), 0);
    check_eq("rst_bad", 32'(bad_press), 0);
    check_eq("rst_miss", 32'(miss_pulse), 0);
    check_eq("rst_vis", 32'(note_visible), 0);
    rst_n = 1'b1;

    // Fill lane 2, then a fifth request must be refused.
    start = 1'b1; spawn_valid = 1'b1; spawn_lane = 3'd2;
    repeat (4) cycle();
    #1 check_eq("fill_ready_off", 32'(spawn_ready), 0);
    cycle();
    spawn_valid = 1'b0;

    // Asynchronous reset with notes on screen.
    h_count = 10'd370; v_count = 10'(m_y[2][0] + 1);
    #1 check_eq("pre_rst_vis", 32'(note_visible), 1);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_eq("mid_rst_vis", 32'(note_visible), 0);
    check_eq("mid_rst_hit", 32'(hit_pulse), 0);
    check_eq("mid_rst_bad", 32'(bad_press), 0);
    check_eq("mid_rst_miss", 32'(miss_pulse), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; spawn_lane = 3'd0;
    cycle();
    #1 check_eq("rst_ready0", 32'(spawn_ready), 1);

    // Motion and visibility in lane 1.
    spawn_valid = 1'b1; spawn_lane = 3'd1;
    cycle();
    spawn_valid = 1'b0;
    for (int k = 0; k < 200 && m_y[1][0] != 20; k++) cycle();
    h_count = 10'd220; v_count = 10'd20;
    #1 check_eq("vis_y20", 32'(note_visible), 1);
    check_eq("lane_y20", 32'(note_lane), 1);
    v_count = 10'd40;
    #1 check_eq("vis_v40", 32'(note_visible), 0);

    // Press inside the window (bottom 424).
    for (int k = 0; k < 2000 && m_y[1][0] != 404; k++) cycle();
    hit_req = 4'b0010;
    cycle();
    hit_req = '0;
    check_eq("hit_win", 32'(hit_pulse[1]), 1);
    h_count = 10'd220; v_count = 10'd414;
    #1 check_eq("hit_gone", 32'(note_visible), 0);
    cycle();
    check_eq("hit_once", 32'(hit_pulse[1]), 0);

    // Press too early (bottom 400).
    spawn_valid = 1'b1; spawn_lane = 3'd1;
    cycle();
    spawn_valid = 1'b0;
    for (int k = 0; k < 2000 && m_y[1][0] != 380; k++) cycle();
    hit_req = 4'b0010;
    cycle();
    hit_req = '0;
    check_eq("bad_press1", 32'(bad_press[1]), 1);
    check_eq("bad_nohit", 32'(hit_pulse[1]), 0);
    h_count = 10'd250; v_count = 10'd385;
    #1 check_eq("bad_keep", 32'(note_visible), 1);

    // Lane 3 note falls off the bottom.
    spawn_valid = 1'b1; spawn_lane = 3'd3;
    cycle();
    spawn_valid = 1'b0;
    for (int k = 0; k < 1500 && miss_pulse[3] !== 1'b1; k++) cycle();
    check_eq("miss3", 32'(miss_pulse[3]), 1);
    spawn_lane = 3'd3;
    #1 check_eq("miss_free", 32'(spawn_ready), 1);
    cycle();
    check_eq("miss_once", 32'(miss_pulse[3]), 0);

    // Press and tick together at bottom 456: hit wins.
    spawn_valid = 1'b1; spawn_lane = 3'd2;
    cycle();
    spawn_valid = 1'b0;
    for (int k = 0; k < 3000 && !(m_y[2][0] == 436 && m_cnt == TD - 1); k++) cycle();
    hit_req = 4'b0100;
    cycle();
    hit_req = '0;
    check_eq("sim_hit", 32'(hit_pulse[2]), 1);
    check_eq("sim_nomiss", 32'(miss_pulse[2]), 0);

    // Spawn on a tick cycle stays at y=0.
    for (int k = 0; k < 8 && m_cnt != TD - 1; k++) cycle();
    spawn_valid = 1'b1; spawn_lane = 3'd0;
    cycle();
    spawn_valid = 1'b0;
    h_count = 10'd170; v_count = 10'd0;
    #1 check_eq("tick_spawn_y0", 32'(note_visible), 1);
    check_eq("tick_spawn_lane", 32'(note_lane), 0);
    v_count = 10'd20;
    #1 check_eq("tick_spawn_v20", 32'(note_visible), 0);

    repeat (3000) begin
      rand_inputs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
